// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StAck,
    StWaitIdle,
    StDone
  } ps2_tx_state_e;

  // Device clock falls: 9 payload bits plus the stop-bit slot, then the ACK slot.
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned ACK_BIT    = 10;

  // 120 us inhibit and 20 ms inter-edge timeout at 50 MHz.
  localparam int unsigned DEF_INHIBIT_CYCLES = 6000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/ps2_tx_edge.sv
// Two-flop synchronizer for one PS/2 pin plus a registered falling-edge pulse.
module ps2_tx_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q, fall_q;

  // Reset to the idle-high line level so reset release never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_tx_funcmod.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte
// with odd parity on device clock falls, then collect the device ACK.
module ps2_tx_funcmod
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLOCK,
  input  logic       RST,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       oClkOE,
  output logic       oDatOE,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);

  ps2_tx_state_e   state_q, state_d;
  logic [8:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0] inh_q, inh_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            dat_q, dat_d;
  logic            err_q, err_d;
  logic            dat_meta_q, dat_sync_q;
  logic            clk_lvl, clk_fall, timed;

  ps2_tx_edge u_clk_edge (
    .clk_i   (CLOCK),
    .rst_i   (RST),
    .pin_i   (PS2_CLK),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_q     <= '0;
      tmo_q     <= '0;
      dat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_q     <= inh_d;
      tmo_q     <= tmo_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_d     = inh_q;
    tmo_d     = '0;
    dat_d     = dat_q;
    err_d     = err_q;
    timed     = state_q inside {StSend, StAck, StWaitIdle};

    if (timed && !clk_fall) begin
      tmo_d = (tmo_q == TmoMax) ? tmo_q : tmo_q + TmoW'(1);
    end

    unique case (state_q)
      StIdle: begin
        dat_d = 1'b0;
        if (iStart) begin
          shift_d   = {~^iData, iData};
          bit_cnt_d = '0;
          inh_d     = '0;
          err_d     = 1'b0;
          state_d   = StInhibit;
        end
      end
      StInhibit: begin
        inh_d = inh_q + InhW'(1);
        if (inh_q == InhLast) state_d = StReq;
      end
      StReq: begin
        dat_d   = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (clk_fall) begin
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            dat_d     = 1'b0;
            bit_cnt_d = 4'(ACK_BIT);
            state_d   = StAck;
          end else begin
            dat_d     = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StAck: begin
        if (clk_fall) begin
          err_d   = dat_sync_q;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_lvl && dat_sync_q) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A silent device aborts the transfer from any clocked state.
    if (timed && tmo_d == TmoMax) begin
      dat_d   = 1'b0;
      err_d   = 1'b1;
      state_d = StDone;
    end
  end

  always_comb begin
    oClkOE = state_q inside {StInhibit, StReq};
    oDatOE = (state_q == StReq) || ((state_q == StSend) && dat_q);
    oBusy  = (state_q != StIdle) && (state_q != StDone);
    oDone  = (state_q == StDone);
    oErr   = (state_q == StDone) && err_q;
  end

endmodule
